// File: rtl/si_header_pkg.sv
// Shared constants and types for the Time Tagger header filter.
// Byte offsets index the first beat in tdata byte order.
package si_header_pkg;

  localparam logic [15:0] ETHERTYPE_SI = 16'h9B80;
  localparam logic [31:0] MAGIC_SITT   = 32'h54544953;

  localparam int OFF_ETH   = 12;
  localparam int OFF_MAGIC = 14;
  localparam int OFF_VER   = 18;
  localparam int OFF_TYPE  = 19;
  localparam int OFF_SEQ   = 24;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } hdr_state_t;

  typedef struct packed {
    logic [15:0] eth;
    logic [31:0] magic;
    logic [7:0]  ver;
    logic [7:0]  typ;
    logic [31:0] seq;
  } hdr_fields_t;

  function automatic hdr_fields_t get_hdr(
    input logic [255:0] b
  );
    hdr_fields_t f;
    f.eth   = b[OFF_ETH*8   +: 16];
    f.magic = b[OFF_MAGIC*8 +: 32];
    f.ver   = b[OFF_VER*8   +: 8];
    f.typ   = b[OFF_TYPE*8  +: 8];
    f.seq   = b[OFF_SEQ*8   +: 32];
    return f;
  endfunction

endpackage

// File: rtl/si_axis_skid_reg.sv
// Two-entry registered AXI4-Stream output stage.
// Ready is a register, so no combinational path crosses it.
module si_axis_skid_reg #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [KEEP_WIDTH-1:0] out_keep
);

  localparam int W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [W-1:0] in_b;
  logic [W-1:0] out_q;
  logic [W-1:0] sk_q;
  logic         out_v;
  logic         sk_v;
  logic         push;
  logic         pop;
  logic         load_in;
  logic         load_sk;
  logic         pop_sk;
  logic         drain;

  assign in_b     = {in_last, in_keep, in_data};
  assign in_ready = !sk_v;
  assign push     = in_valid && in_ready;
  assign pop      = out_v && out_ready;

  assign load_in = push && (!out_v || out_ready);
  assign load_sk = push && out_v && !out_ready;
  assign pop_sk  = !push && pop && sk_v;
  assign drain   = !push && pop && !sk_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sk_q  <= '0;
      out_v <= 1'b0;
      sk_v  <= 1'b0;
    end else begin
      unique case (1'b1)
        load_in: begin
          out_q <= in_b;
          out_v <= 1'b1;
        end
        load_sk: begin
          sk_q <= in_b;
          sk_v <= 1'b1;
        end
        pop_sk: begin
          out_q <= sk_q;
          sk_v  <= 1'b0;
        end
        drain: out_v <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = out_v;
  assign {out_last, out_keep, out_data} = out_q;

endmodule

// File: rtl/si_header_filter.sv
// Time Tagger header parser: validates beat 0, drops foreign
// frames whole, tracks sequence gaps and keeps frame statistics.
module si_header_filter
  import si_header_pkg::*;
#(
  parameter int         DATA_WIDTH  = 256,
  parameter int         KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter logic [7:0] MAX_VERSION = 8'h00,
  parameter logic [7:0] ACCEPT_TYPE = 8'h00,
  parameter int         CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  input  logic                  clear_stats,
  output logic                  lost_packet,
  output logic [CNT_WIDTH-1:0]  lost_count,
  output logic [CNT_WIDTH-1:0]  pass_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  invalid_packet
);

  if (DATA_WIDTH != 256 && DATA_WIDTH != 512) begin : g_bad_width
    $error("si_header_filter: DATA_WIDTH must be 256 or 512");
  end

  localparam int SW = ((CNT_WIDTH > 32) ? CNT_WIDTH : 32) + 1;
  localparam logic [SW-1:0] CNT_MAX =
    {{(SW-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  hdr_state_t  state;
  hdr_state_t  state_d;
  hdr_fields_t hf;
  logic        hdr_ok;
  logic        skid_ready;
  logic        s_hs;
  logic        in_hdr;
  logic        in_pass;
  logic        hdr_take;
  logic        hdr_drop;
  logic        pass_end;
  logic        fwd;
  logic        synced;
  logic [31:0] expected_seq;
  logic [31:0] gap;
  logic        seq_gap;
  logic [SW-1:0]        lost_sum;
  logic [CNT_WIDTH-1:0] lost_next;

  assign hf = get_hdr(s_axis_tdata[255:0]);

  assign hdr_ok = (&s_axis_tkeep[31:0])
    && (hf.eth == ETHERTYPE_SI)
    && (hf.magic == MAGIC_SITT)
    && (hf.ver <= MAX_VERSION)
    && (hf.typ == ACCEPT_TYPE)
    && !s_axis_tlast;

  assign in_hdr  = (state == HDR);
  assign in_pass = (state == PASS);

  // Ready never looks at tdata; the header check only steers the push.
  assign s_axis_tready = (state == DROP) ? 1'b1 : skid_ready;
  assign s_hs          = s_axis_tvalid && s_axis_tready;

  assign hdr_take = s_hs && in_hdr && hdr_ok;
  assign hdr_drop = s_hs && in_hdr && !hdr_ok;
  assign pass_end = s_hs && in_pass && s_axis_tlast;
  assign fwd      = s_hs && (in_pass || (in_hdr && hdr_ok));

  always_comb begin
    state_d = state;
    unique case (1'b1)
      hdr_take: state_d = PASS;
      hdr_drop: state_d = s_axis_tlast ? HDR : DROP;
      (s_hs && !in_hdr && s_axis_tlast): state_d = HDR;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HDR;
    end else begin
      state <= state_d;
    end
  end

  assign invalid_packet = (state == DROP);

  // Sequence zero is a sender restart: resync without counting loss.
  assign gap     = hf.seq - expected_seq;
  assign seq_gap = hdr_take && synced
    && (hf.seq != 32'd0) && (hf.seq != expected_seq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synced       <= 1'b0;
      expected_seq <= 32'd0;
    end else if (hdr_take) begin
      synced       <= 1'b1;
      expected_seq <= hf.seq + 32'd1;
    end
  end

  assign lost_sum  = SW'(lost_count) + SW'(gap);
  assign lost_next = (lost_sum > CNT_MAX) ?
    {CNT_WIDTH{1'b1}} : lost_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count  <= '0;
      drop_count  <= '0;
      lost_count  <= '0;
      lost_packet <= 1'b0;
    end else if (clear_stats) begin
      pass_count  <= '0;
      drop_count  <= '0;
      lost_count  <= '0;
      lost_packet <= 1'b0;
    end else begin
      if (pass_end) begin
        pass_count <= pass_count + CNT_WIDTH'(~&pass_count);
      end
      if (hdr_drop) begin
        drop_count <= drop_count + CNT_WIDTH'(~&drop_count);
      end
      if (seq_gap) begin
        lost_packet <= 1'b1;
        lost_count  <= lost_next;
      end
    end
  end

  si_axis_skid_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fwd),
    .in_ready (skid_ready),
    .in_data  (s_axis_tdata),
    .in_last  (s_axis_tlast),
    .in_keep  (s_axis_tkeep),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data (m_axis_tdata),
    .out_last (m_axis_tlast),
    .out_keep (m_axis_tkeep)
  );

endmodule

// File: tb/tb_si_header_filter.sv
// Directed bench for si_header_filter with an output scoreboard
// and a stall-stability monitor.
module tb_si_header_filter;
  import si_header_pkg::*;

  localparam int DW = 256;
  localparam int KW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [KW-1:0] s_keep;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [KW-1:0] m_keep;
  logic          clear_stats;
  logic          lost_packet;
  logic [CW-1:0] lost_count;
  logic [CW-1:0] pass_count;
  logic [CW-1:0] drop_count;
  logic          invalid_packet;

  always #5 clk = ~clk;

  si_header_filter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .s_axis_tkeep  (s_keep),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tkeep  (m_keep),
    .clear_stats   (clear_stats),
    .lost_packet   (lost_packet),
    .lost_count    (lost_count),
    .pass_count    (pass_count),
    .drop_count    (drop_count),
    .invalid_packet(invalid_packet)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_out = 0;
  bit lat_mode = 1'b0;
  bit aborted = 1'b0;
  bit rnd_ready = 1'b0;
  bit ready_val = 1'b0;

  logic [DW-1:0] q_data[$];
  logic [KW-1:0] q_keep[$];
  logic          q_last[$];
  int            q_cyc[$];

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : ready_val;
    end
  end

  // Output monitor: scoreboard pops and stall stability.
  initial begin
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [KW:0]   prev_side;
    logic [DW-1:0] ed;
    int            c;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_side = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_side", {m_last, m_keep}, prev_side);
      end
      prev_stall = rst_n && m_valid && !m_ready;
      prev_data = m_data;
      prev_side = {m_last, m_keep};
      if (rst_n && m_valid && m_ready) begin
        n_out++;
        if (q_data.size() == 0) begin
          check("out_extra", 1, 0);
        end else begin
          ed = q_data.pop_front();
          check("out_data", m_data, ed);
          check("out_keep", m_keep, q_keep.pop_front());
          check("out_last", m_last, q_last.pop_front());
          c = q_cyc.pop_front();
          if (lat_mode) check("latency", cyc - c, 1);
        end
      end
    end
  end

  initial begin
    #800000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] d;
    d = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    d[111:96] = 16'h0000;
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_hdr(input logic [15:0] eth,
      input logic [7:0] ver, input logic [7:0] typ,
      input logic [31:0] seq);
    logic [DW-1:0] d;
    d = rnd_beat();
    d[111:96]  = eth;
    d[143:112] = MAGIC_SITT;
    d[151:144] = ver;
    d[159:152] = typ;
    d[223:192] = seq;
    return d;
  endfunction

  task automatic send_beat(input logic [DW-1:0] d,
      input logic [KW-1:0] k, input logic last,
      input bit fwd, input bit chk_drop);
    bit hs;
    int waitc;
    hs = 1'b0;
    waitc = 0;
    if (!aborted) begin
      s_valid = 1'b1;
      s_data = d;
      s_keep = k;
      s_last = last;
      while (!hs && !aborted) begin
        @(negedge clk);
        hs = s_ready;
        if (chk_drop) begin
          check("drop_invalid", invalid_packet, 1);
          check("drop_ready", s_ready, 1);
        end
        if (hs && fwd) begin
          q_data.push_back(d);
          q_keep.push_back(k);
          q_last.push_back(last);
          q_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        waitc++;
        if (!hs && waitc > 300) begin
          check("in_timeout", 0, 1);
          aborted = 1'b1;
        end
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] hdr, input int nb,
      input bit fwd, input bit chk_drop, input logic [KW-1:0] k0);
    logic [DW-1:0] d;
    logic [KW-1:0] kk;
    logic          last;
    for (int i = 0; i < nb; i++) begin
      last = (i == nb - 1);
      d = (i == 0) ? hdr : rnd_beat();
      kk = (i == 0) ? k0 : (last ? 32'h0000FFFF : '1);
      send_beat(d, kk, last, fwd, chk_drop && (i > 0));
    end
  endtask

  task automatic vframe(input logic [31:0] seq, input int nb);
    send_frame(mk_hdr(ETHERTYPE_SI, 8'h00, 8'h00, seq), nb,
               1'b1, 1'b0, '1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_data.size() != 0 || m_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mvalid"}, m_valid, 0);
    check({tag, "_lostpkt"}, lost_packet, 0);
    check({tag, "_lost"}, lost_count, 0);
    check({tag, "_pass"}, pass_count, 0);
    check({tag, "_drop"}, drop_count, 0);
    check({tag, "_inval"}, invalid_packet, 0);
  endtask

  initial begin
    int base;
    int exp_pass;
    int exp_drop;
    int exp_beats;
    int nb;
    int kind;
    logic [31:0] next_seq;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    s_keep = '0;
    clear_stats = 1'b0;
    ready_val = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    check("rst_sready", s_ready, 1);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Three in-order frames, sink always ready.
    lat_mode = 1'b1;
    vframe(32'd5, 4);
    vframe(32'd6, 4);
    vframe(32'd7, 4);
    drain();
    lat_mode = 1'b0;
    check("t1_nout", n_out, 12);
    check("t1_pass", pass_count, 3);
    check("t1_lostpkt", lost_packet, 0);
    check("t1_lost", lost_count, 0);
    check("t1_drop", drop_count, 0);

    // Gaps: 8 expected -> 10 loses 2; 11 expected -> 14 loses 3.
    pulse_clear();
    check("t2_clr_pass", pass_count, 0);
    vframe(32'd10, 4);
    drain();
    check("t2_lost_a", lost_count, 2);
    check("t2_lostpkt_a", lost_packet, 1);
    pulse_clear();
    vframe(32'd14, 4);
    drain();
    check("t2_lostpkt", lost_packet, 1);
    check("t2_lost", lost_count, 3);
    pulse_clear();
    check("t2_clr_lostpkt", lost_packet, 0);
    check("t2_clr_lost", lost_count, 0);
    check("t2_clr_pass2", pass_count, 0);

    // ARP frame between two good frames.
    base = n_out;
    vframe(32'd15, 4);
    send_frame(mk_hdr(16'h0608, 8'h00, 8'h00, 32'd0), 3,
               1'b0, 1'b1, '1);
    vframe(32'd16, 4);
    drain();
    check("t3_nout", n_out - base, 8);
    check("t3_drop", drop_count, 1);
    check("t3_pass", pass_count, 2);
    check("t3_lost", lost_count, 0);

    // Loss accumulation up to saturation.
    vframe(32'hFFFF_FFFF, 2);
    drain();
    check("t4_lost_a", lost_count, 32'hFFFF_FFEE);
    vframe(32'h0000_0010, 2);
    drain();
    check("t4_lost_b", lost_count, 32'hFFFF_FFFE);
    vframe(32'h0000_0020, 2);
    drain();
    check("t4_lost_sat", lost_count, 32'hFFFF_FFFF);
    check("t4_lostpkt", lost_packet, 1);

    // Reset in the middle of a forwarded frame.
    send_beat(mk_hdr(ETHERTYPE_SI, 8'h00, 8'h00, 32'd100), '1,
              1'b0, 1'b1, 1'b0);
    send_beat(rnd_beat(), '1, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_state("mrst");
    q_data.delete();
    q_keep.delete();
    q_last.delete();
    q_cyc.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = n_out;
    send_beat(rnd_beat(), '1, 1'b0, 1'b0, 1'b0);
    send_beat(rnd_beat(), 32'h0000FFFF, 1'b1, 1'b0, 1'b1);
    drain();
    check("mrst_nout", n_out - base, 0);
    check("mrst_drop", drop_count, 1);
    check("mrst_pass", pass_count, 0);

    // Wrap FFFFFFFF -> 0 -> 1 with no loss after resync.
    vframe(32'hFFFF_FFFF, 3);
    vframe(32'h0000_0000, 3);
    vframe(32'h0000_0001, 3);
    drain();
    check("t4w_lost", lost_count, 0);
    check("t4w_lostpkt", lost_packet, 0);
    check("t4w_pass", pass_count, 3);

    // Header field rejections.
    pulse_clear();
    base = n_out;
    send_frame(mk_hdr(ETHERTYPE_SI, 8'h01, 8'h00, 32'd2), 3,
               1'b0, 1'b1, '1);
    send_frame(mk_hdr(ETHERTYPE_SI, 8'h00, 8'h00, 32'd2), 1,
               1'b0, 1'b0, '1);
    drain();
    check("t5_drop2", drop_count, 2);
    send_frame(mk_hdr(ETHERTYPE_SI, 8'h00, 8'h00, 32'd2), 3,
               1'b0, 1'b1, 32'hFFFF_FFFE);
    send_frame(mk_hdr(ETHERTYPE_SI, 8'h00, 8'h01, 32'd2), 2,
               1'b0, 1'b1, '1);
    drain();
    check("t5_drop4", drop_count, 4);
    check("t5_pass", pass_count, 0);
    check("t5_nout", n_out - base, 0);

    // Mixed traffic with a sink ready 30% of the time.
    pulse_clear();
    base = n_out;
    exp_pass = 0;
    exp_drop = 0;
    exp_beats = 0;
    next_seq = 32'd2;
    rnd_ready = 1'b1;
    for (int f = 0; f < 1000 && !aborted; f++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin
        nb = $urandom_range(2, 4);
        vframe(next_seq, nb);
        next_seq = next_seq + 32'd1;
        exp_pass++;
        exp_beats += nb;
      end else if (kind == 2) begin
        nb = $urandom_range(1, 3);
        send_frame(mk_hdr(16'h0008, 8'h00, 8'h00, next_seq), nb,
                   1'b0, 1'b1, '1);
        exp_drop++;
      end else begin
        nb = $urandom_range(2, 3);
        send_frame(mk_hdr(ETHERTYPE_SI, 8'($urandom_range(1, 255)),
                   8'h00, next_seq), nb, 1'b0, 1'b1, '1);
        exp_drop++;
      end
    end
    rnd_ready = 1'b0;
    drain();
    check("rnd_nout", n_out - base, exp_beats);
    check("rnd_pass", pass_count, exp_pass);
    check("rnd_drop", drop_count, exp_drop);
    check("rnd_lost", lost_count, 0);
    check("rnd_lostpkt", lost_packet, 0);
    check("rnd_q_empty", q_data.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
